// File: rtl/uart_pkg.sv
// Shared types and register map for the UART transmitter with TX FIFO.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } ser_state_e;

    localparam logic [7:0] TXD_OFS = 8'h18;
    localparam logic [7:0] CON_OFS = 8'h20;

    // Bit positions inside the CON register
    localparam int unsigned CON_BUSY  = 0;
    localparam int unsigned CON_FULL  = 1;
    localparam int unsigned CON_EMPTY = 2;
    localparam int unsigned CON_IEN   = 3;
    localparam int unsigned CON_DONE  = 4;
    localparam int unsigned CON_OVF   = 5;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Memory-mapped load/store bus between the CPU MEM stage and the UART.
interface uart_tx_fifo_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output wr_en, output rd_en, output addr, output wdata, input rdata);
    modport slave  (input wr_en, input rd_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_ser.sv
// UART frame serializer: start, 8 data bits LSB first, optional even parity, stop.
// Parity bit is present only when UART_TX_PARITY_EN is defined.
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_data_i,
    output logic       pop_o,
    output logic       done_o,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int unsigned   BaudW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BaudW-1:0] BaudLoad = BaudW'(BAUD_DIV - 1);

    ser_state_e        state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              tick;
    logic              load;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    always_comb begin
        tick    = (baud_q == '0);
        state_d = state_q;
        baud_d  = tick ? '0 : baud_q - BaudW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_o  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        // A new frame starts from IDLE or straight out of STOP, with no idle gap
        load = !fifo_empty_i && ((state_q == StIdle) || ((state_q == StStop) && tick));

        case (state_q)
            StStart: begin
                if (tick) begin
                    state_d = StData;
                    baud_d  = BaudLoad;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (tick) begin
                    baud_d = BaudLoad;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                    baud_d  = BaudLoad;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    done_o  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d = StStart;
            baud_d  = BaudLoad;
            shift_d = fifo_data_i;
            tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_data_i;
`endif
        end
        pop_o = load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign busy_o = (state_q != StIdle);
    assign tx_o   = tx_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: TXD/CON registers, byte FIFO and serializer.
// Define UART_TX_PARITY_EN to add an even-parity bit to every frame.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 5208,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_fifo_if.slave bus,
    output logic         tx,
    output logic         irq
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      last_q, last_d;
    logic            ien_q, ien_d, done_q, done_d, ovf_q, ovf_d;

    logic [7:0]  ofs;
    logic        push, accept, con_wr, con_rd;
    logic        fifo_empty, fifo_full;
    logic        ser_pop, ser_done, ser_busy;
    logic [5:0]  con;
    logic [31:0] rdata;
    logic        unused_bits;

    assign ofs         = bus.addr[7:0];
    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == DepthCnt);
    assign unused_bits = ^{bus.addr[31:8], bus.wdata[31:8]};

    always_comb begin
        push   = bus.wr_en && (ofs == TXD_OFS);
        con_wr = bus.wr_en && (ofs == CON_OFS);
        con_rd = bus.rd_en && (ofs == CON_OFS);
        // A full FIFO still takes a byte when the serializer pops on the same edge
        accept = push && (!fifo_full || ser_pop);

        wr_ptr_d = accept  ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = ser_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        case ({accept, ser_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        last_d = accept ? bus.wdata[7:0] : last_q;
        ien_d  = con_wr ? bus.wdata[CON_IEN] : ien_q;
        done_d = ser_done ? 1'b1 : (con_rd ? 1'b0 : done_q);
        ovf_d  = (push && !accept) ? 1'b1 : (con_rd ? 1'b0 : ovf_q);

        con            = '0;
        con[CON_BUSY]  = ser_busy;
        con[CON_FULL]  = fifo_full;
        con[CON_EMPTY] = fifo_empty;
        con[CON_IEN]   = ien_q;
        con[CON_DONE]  = done_q;
        con[CON_OVF]   = ovf_q;

        rdata = '0;
        if (!reset && bus.rd_en) begin
            case (ofs)
                TXD_OFS: rdata = {24'd0, last_q};
                CON_OFS: rdata = {26'd0, con};
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            ien_q    <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            ien_q    <= ien_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: pointers and count define which slots are valid
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= bus.wdata[7:0];
        end
    end

    uart_tx_ser #(
        .BAUD_DIV(BAUD_DIV)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty_i(fifo_empty),
        .fifo_data_i (mem_q[rd_ptr_q]),
        .pop_o       (ser_pop),
        .done_o      (ser_done),
        .busy_o      (ser_busy),
        .tx_o        (tx)
    );

    assign bus.rdata = rdata;
    assign irq       = ien_q & done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: register table, frame bursts, reset abort.
module tb_uart_tx_fifo;

    localparam int BAUD   = 4;
    localparam int FIFO_D = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic [31:0] TXD = 32'h18;
    localparam logic [31:0] CON = 32'h20;

    logic clk;
    logic reset;
    logic tx;
    logic irq;
    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .BAUD_DIV  (BAUD),
        .FIFO_DEPTH(FIFO_D)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .tx   (tx),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] bq[$];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        #1;
        d = bus.rdata;
        tick();
        bus.rd_en = 1'b0;
    endtask

    // Sends bq[0..k-1] on consecutive cycles and checks the line against frame arithmetic
    task automatic run_burst(input int k, input bit ien);
        int nacc, fb, endc, t, fr, sym;
        logic [7:0]  b;
        logic        exp_tx;
        logic [31:0] exp_con, rd, wd;
        nacc = (k > FIFO_D + 1) ? FIFO_D + 1 : k;
        fb   = FRAME_BITS * BAUD;
        endc = nacc * fb + 1;
        cpu_write(CON, {28'd0, ien, 3'd0});
        for (int cyc = 0; cyc <= endc; cyc++) begin
            if (cyc < k) begin
                wd        = $urandom();
                wd[7:0]   = bq[cyc];
                bus.wr_en = 1'b1;
                bus.addr  = TXD;
                bus.wdata = wd;
            end
            if (cyc == k + 1 || cyc == k + 2) begin
                bus.rd_en = 1'b1;
                bus.addr  = CON;
                #1;
                exp_con = {26'd0, (cyc == k + 1) && (k > nacc), 1'b0, ien,
                           nacc == 1, nacc - 1 == FIFO_D, 1'b1};
                check("con_mid", bus.rdata, exp_con);
            end
            tick();
            bus.wr_en = 1'b0;
            bus.rd_en = 1'b0;
            t = cyc - 1;
            if (t < 0 || t >= nacc * fb) begin
                exp_tx = 1'b1;
            end else begin
                fr  = t / fb;
                sym = (t % fb) / BAUD;
                b   = bq[fr];
                if (sym == 0) exp_tx = 1'b0;
                else if (sym <= 8) exp_tx = b[sym-1];
                else if (FRAME_BITS == 11 && sym == 9) exp_tx = ^b;
                else exp_tx = 1'b1;
            end
            check("tx", tx, exp_tx);
            check("irq", irq, ien && (cyc >= fb + 1));
        end
        cpu_read(CON, rd);
        check("con_end_done", rd, 32'h14 | {28'd0, ien, 3'd0});
        check("irq_cleared", irq, 1'b0);
        cpu_read(CON, rd);
        check("con_end_clr", rd, 32'h04 | {28'd0, ien, 3'd0});
        cpu_read(TXD, rd);
        check("txd_last", rd, {24'd0, bq[nacc-1]});
        cpu_write(CON, 32'h0);
    endtask

    vec_t        tbl[13];
    logic [31:0] rd;
    int          lowcnt;

    initial begin
        tbl[0]  = '{0, 32'h20,  32'h0,        32'h04};
        tbl[1]  = '{0, 32'h18,  32'h0,        32'h00};
        tbl[2]  = '{0, 32'h00,  32'h0,        32'h00};
        tbl[3]  = '{1, 32'h20,  32'h08,       32'h00};
        tbl[4]  = '{0, 32'h20,  32'h0,        32'h0C};
        tbl[5]  = '{0, 32'h120, 32'h0,        32'h0C};
        tbl[6]  = '{1, 32'h20,  32'hFFFF_FFF7, 32'h00};
        tbl[7]  = '{0, 32'h20,  32'h0,        32'h04};
        tbl[8]  = '{1, 32'h24,  32'hFF,       32'h00};
        tbl[9]  = '{1, 32'h1C,  32'hAB,       32'h00};
        tbl[10] = '{0, 32'h20,  32'h0,        32'h04};
        tbl[11] = '{0, 32'h1C,  32'h0,        32'h00};
        tbl[12] = '{0, 32'h18,  32'h0,        32'h00};

        reset     = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        tick();
        tick();
        bus.rd_en = 1'b1;
        bus.addr  = CON;
        #1;
        check("rdata_in_reset", bus.rdata, 32'h0);
        tick();
        bus.rd_en = 1'b0;
        check("tx_reset", tx, 1'b1);
        check("irq_reset", irq, 1'b0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) begin
                cpu_write(tbl[i].addr, tbl[i].wdata);
            end else begin
                cpu_read(tbl[i].addr, rd);
                check($sformatf("table[%0d]", i), rd, tbl[i].exp);
            end
        end

        bq = {8'h55};
        run_burst(1, 1'b0);
        bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        run_burst(9, 1'b0);
        bq = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
        run_burst(10, 1'b0);
        bq = {8'hC3};
        run_burst(1, 1'b1);
        bq = {8'h07};
        run_burst(1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int k;
            k = $urandom_range(1, 12);
            bq.delete();
            for (int j = 0; j < k; j++) bq.push_back(8'($urandom()));
            run_burst(k, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of data bit 3 with bytes still queued
        cpu_write(CON, 32'h08);
        cpu_write(TXD, 32'hA5);
        cpu_write(TXD, 32'h3C);
        cpu_write(TXD, 32'hF0);
        for (int i = 0; i < 16; i++) tick();
        check("tx_bit3", tx, 1'b0);
        reset     = 1'b1;
        bus.rd_en = 1'b1;
        bus.addr  = CON;
        #1;
        check("rdata_in_reset2", bus.rdata, 32'h0);
        tick();
        reset     = 1'b0;
        bus.rd_en = 1'b0;
        check("tx_after_reset", tx, 1'b1);
        cpu_read(CON, rd);
        check("con_after_reset", rd, 32'h04);
        lowcnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1) lowcnt++;
        end
        check("no_frames_after_reset", lowcnt, 0);
        check("irq_after_reset", irq, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 5208, clk cycles per UART bit (50 MHz / 9600).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX byte slots (power of 2).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1, MEM-stage store strobe, already qualified by peripheral select.
REQ-006 SHALL have port rd_en, input, 1, MEM-stage load strobe.
REQ-007 SHALL have port addr, input, 32, byte address; only addr[7:0] decoded.
REQ-008 SHALL have port wdata, input, 32, store data.
REQ-009 SHALL have port rdata, output, 32, load data, combinational.
REQ-010 SHALL have port tx, output, 1, serial line, idle high.
REQ-011 SHALL have port irq, output, 1, TX-done interrupt.

Function
REQ-012 Offset 0x18 (TXD): write pushes wdata[7:0] into FIFO; read returns {24'd0, last pushed byte}.
REQ-013 Offset 0x20 (CON): read returns {26'd0, ovf, done, ien, empty, full, busy} in bits [5:0]; write updates ien from wdata[3] only.
REQ-014 Unmapped offsets: reads return 0, writes ignored.
REQ-015 Read of CON with rd_en SHALL clear done and ovf at the next edge; a same-cycle set wins over clear.
REQ-016 Push when count==FIFO_DEPTH and no same-cycle pop: byte dropped, ovf set; push with same-cycle pop when full: accepted.
REQ-017 Serializer states IDLE, START, DATA, STOP (PARITY under REQ-026); IDLE->START when FIFO non-empty, popping head the same edge.
REQ-018 Each non-IDLE state lasts exactly BAUD_DIV cycles; baud counter reloads to BAUD_DIV-1 on state entry, counts to 0.
REQ-019 DATA sends 8 bits LSB first; bit index 0..7 then STOP; tx=0 in START, 1 in STOP/IDLE.
REQ-020 STOP exit: done set; to START directly if FIFO non-empty (back-to-back frames, no idle gap), else IDLE.
REQ-021 Latency: TXD write at edge N with FIFO empty and IDLE -> byte stored at N, tx falls after edge N+1.
REQ-022 busy=1 whenever state!=IDLE; full/empty reflect count after the latest edge; irq = ien & done.

Reset
REQ-023 While reset high at an edge: state IDLE, tx=1, FIFO count/pointers 0, done=0, ovf=0, ien=0, baud counter 0.
REQ-024 Reset mid-frame SHALL abort it; tx high at the following cycle; queued bytes discarded.
REQ-025 rdata SHALL be 0 during reset regardless of rd_en.

Configuration
REQ-026 With UART_TX_PARITY_EN defined: PARITY state between DATA and STOP sends even parity (XOR of 8 data bits), frame 11 bit-times; undefined: 10 bit-times, no PARITY state.

Structure
REQ-027 Shared package uart_pkg: state enum, offsets TXD_OFS=0x18 and CON_OFS=0x20, CON bit-position constants.
REQ-028 One sub-module uart_tx_ser (state machine, baud counter, shift register); FIFO and register decode in top.

Verification (BAUD_DIV=4, FIFO_DEPTH=8)
REQ-029 Write 0x55 to TXD from idle -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), high 4; done=1 after 40 cycles.
REQ-030 Write 9 bytes back-to-back in 9 cycles -> first popped; all 9 stored, ovf=0; 9 frames with no idle gap.
REQ-031 Write 10 bytes in 10 cycles -> 10th dropped, CON read = ovf|busy|full set, i.e. 0x23 (bits 5,1,0); read clears ovf next edge.
REQ-032 Write CON 0x08, send one byte -> irq rises with done at frame end; CON read drops irq next cycle.
REQ-033 Assert reset during bit 3 of a frame -> tx=1 next cycle, CON reads 0x04 (empty), no further frames.
REQ-034 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1, frame 44 cycles; without, 40 cycles.
